vga_timing_gen: RTL

Parametrised VGA raster timing generator, the next generation of the team's fixed 640x480 sync controller. It sits between the pixel clock domain and the frame-buffer read / draw logic, and supplies:
- h/v sync with configurable polarity;
- pixel coordinates and a video-on window;
- an integer pixel-clock divider;
- line, frame and vblank strobes;
- a run/stop control that only halts on a frame boundary.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_axis_counter.sv | 65 ++++++
 rtl/vga_timing_gen.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 timing constants and the line/frame total helper
// for the VGA raster timing generator.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } vga_state_e;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_PIX_DIV  = 2;
  localparam int unsigned VGA_CNT_W    = 10;
  localparam int unsigned VGA_FRAME_W  = 16;

  function automatic int unsigned vga_total(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync,
                                            input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and active flags
// that always describe the count presented in the same clock.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned CNT_W  = VGA_CNT_W,
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter bit          POL    = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o,
  output logic             sync_o,
  output logic             active_o
);

  localparam int unsigned      TOTAL   = vga_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] ACT_LIM = CNT_W'(ACTIVE);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sync_q, sync_d;
  logic             active_q, active_d;

  assign wrap_o = (count_q == LAST);

  // Flags are decoded from the next count so they line up with it once registered.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (advance_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
    sync_d   = ((count_d >= SYNC_LO) && (count_d < SYNC_HI)) ? POL : ~POL;
    active_d = !clear_i && (count_d < ACT_LIM);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      sync_q   <= ~POL;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sync_q   <= sync_d;
      active_q <= active_d;
    end
  end

  assign count_o  = count_q;
  assign sync_o   = sync_q;
  assign active_o = active_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with run/stop control that halts only on a
// frame boundary. Define VGA_TIMING_FRAME_COUNT_EN to add the completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned PIX_DIV    = VGA_PIX_DIV,
  parameter int unsigned CNT_W      = VGA_CNT_W
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  parameter int unsigned FRAME_W    = VGA_FRAME_W
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic             running,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             h_sync,
  output logic             v_sync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [FRAME_W-1:0] frame_count
`endif
);

  localparam int unsigned      H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned      V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam longint unsigned  CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
  localparam int unsigned      DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [CNT_W-1:0] V_PRE_BLANK = CNT_W'(V_ACTIVE - 1);

  if ((64'(H_TOTAL) - 64'd1 > CNT_MAX) || (64'(V_TOTAL) - 64'd1 > CNT_MAX)) begin : g_cnt_w_check
    $error("vga_timing_gen: CNT_W cannot hold H_TOTAL-1 / V_TOTAL-1");
  end
  if (PIX_DIV < 1) begin : g_pix_div_check
    $error("vga_timing_gen: PIX_DIV must be at least 1");
  end

  vga_state_e       state_q, state_d;
  logic             running_q, run_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             h_wrap, v_wrap, h_active, v_active;
  logic             frame_wrap, first_start, line_adv;
  logic             line_start_q, frame_start_q, vblank_start_q;

  assign pix_tick    = running_q && (div_q == DIV_LAST);
  assign frame_wrap  = pix_tick && h_wrap && v_wrap;
  assign first_start = (state_q == IDLE) && enable;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (enable) state_d = RUN;
      RUN:      if (!enable) state_d = STOPPING;
      STOPPING: begin
        if (enable)          state_d = RUN;
        else if (frame_wrap) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  assign run_d    = (state_d != IDLE);
  assign line_adv = pix_tick && h_wrap && run_d;

  // The divider starts from 0 in the first running cycle, so the first tick lands PIX_DIV
  // clocks after enable is sampled.
  always_comb begin
    div_d = div_q + 1'b1;
    if (!run_d || !running_q || pix_tick) div_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      running_q      <= 1'b0;
      div_q          <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      running_q      <= run_d;
      div_q          <= div_d;
      line_start_q   <= first_start || line_adv;
      frame_start_q  <= first_start || (frame_wrap && run_d);
      vblank_start_q <= line_adv && (v_count == V_PRE_BLANK);
    end
  end

  vga_axis_counter #(
    .CNT_W (CNT_W),
    .ACTIVE(H_ACTIVE),
    .FP    (H_FP),
    .SYNC  (H_SYNC),
    .BP    (H_BP),
    .POL   (H_SYNC_POL)
  ) u_h_axis (
    .clock    (clock),
    .reset    (reset),
    .advance_i(pix_tick),
    .clear_i  (!run_d),
    .count_o  (h_count),
    .wrap_o   (h_wrap),
    .sync_o   (h_sync),
    .active_o (h_active)
  );

  vga_axis_counter #(
    .CNT_W (CNT_W),
    .ACTIVE(V_ACTIVE),
    .FP    (V_FP),
    .SYNC  (V_SYNC),
    .BP    (V_BP),
    .POL   (V_SYNC_POL)
  ) u_v_axis (
    .clock    (clock),
    .reset    (reset),
    .advance_i(pix_tick && h_wrap),
    .clear_i  (!run_d),
    .count_o  (v_count),
    .wrap_o   (v_wrap),
    .sync_o   (v_sync),
    .active_o (v_active)
  );

  // Both active flags are cleared whenever the raster stops, so this already implies running.
  assign video_on     = h_active && v_active;
  assign running      = running_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign vblank_start = vblank_start_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [FRAME_W-1:0] frame_count_q;

  // Counts only wrap-generated frame starts; survives IDLE so software sees a running total.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (frame_wrap && run_d) begin
      frame_count_q <= frame_count_q + 1'b1;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule
